// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo
// Multi-cycle control unit for the shared-ALU datapath (PC, IR, register
// file, ALU operand muxes, unified RAM). Each instruction is walked through
// fetch, decode, execute, memory and write-back states. Memory accesses take
// MEM_WAIT extra wait cycles. IN/OUT instructions block on valid/ready
// handshakes. HALT, and any unknown opcode, park the unit in a sticky halt
// state. A retired-instruction counter is kept.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   opcode, funct            IR[31:26] and IR[5:0]
//   zero                     ALU zero flag (branch decision)
//   in_valid / in_ack        switch-input handshake
//   out_ready / out_valid    display-output handshake
//   pc_write, pc_src         PC load enable and source select
//   ir_write                 IR load enable
//   mem_read, mem_write      RAM strobes; i_or_d picks the RAM address source
//   reg_write, reg_dst,
//   mem_to_reg               register-file write enable, dest and data select
//   alu_src_a, alu_src_b,
//   alu_op                   ALU operand selects and operation class
//   halted, illegal          sticky halt flags
//   state                    current FSM state (debug)
//   instr_count              retired-instruction counter (wraps)
module unidade_controle_multiciclo #(
    parameter int         MEM_WAIT = 1,
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_BNE   = 6'h05,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_JAL   = 6'h03,
    parameter logic [5:0] OP_IN    = 6'h3E,
    parameter logic [5:0] OP_OUT   = 6'h3F,
    parameter logic [5:0] OP_HALT  = 6'h3D,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_ANDI  = 6'h0C,
    parameter logic [5:0] OP_ORI   = 6'h0D,
    parameter logic [5:0] OP_SLTI  = 6'h0A,
    parameter logic [5:0] FUNCT_JR = 6'h08
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        in_ack,
    output logic        out_valid,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        IN_WAIT   = 4'd10,
        OUT_WAIT  = 4'd11,
        ALU_WB    = 4'd12,
        HALT      = 4'd13
    } stateT;

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

    stateT      currState;
    logic [3:0] wc;
    logic       waitDone;

    // A memory access lasts WAIT_LIMIT+1 cycles; the last one is when the
    // wait counter has reached the limit.
    assign waitDone = (wc >= WAIT_LIMIT);
    assign state    = currState;

    // State register, wait counter, sticky halt flags and retire counter.
    // Every transition that lands in FETCH from another state, and the single
    // transition into HALT, retires one instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            currState   <= FETCH;
            wc          <= 4'd0;
            instr_count <= 32'd0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            case (currState)
                FETCH: begin
                    if (!waitDone) begin
                        wc <= wc + 4'd1;
                    end else begin
                        wc        <= 4'd0;
                        currState <= DECODE;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:                         currState <= (funct == FUNCT_JR) ? JUMP : EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: currState <= EXEC_I;
                        OP_LW, OP_SW:                     currState <= MEM_ADDR;
                        OP_BEQ, OP_BNE:                   currState <= BRANCH;
                        OP_J, OP_JAL:                     currState <= JUMP;
                        OP_IN:                            currState <= IN_WAIT;
                        OP_OUT:                           currState <= OUT_WAIT;
                        OP_HALT: begin
                            currState   <= HALT;
                            halted      <= 1'b1;
                            instr_count <= instr_count + 32'd1;
                        end
                        default: begin
                            currState   <= HALT;
                            halted      <= 1'b1;
                            illegal     <= 1'b1;
                            instr_count <= instr_count + 32'd1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: currState <= ALU_WB;
                MEM_ADDR:       currState <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                MEM_READ: begin
                    if (!waitDone) begin
                        wc <= wc + 4'd1;
                    end else begin
                        wc        <= 4'd0;
                        currState <= MEM_WB;
                    end
                end
                MEM_WRITE: begin
                    if (!waitDone) begin
                        wc <= wc + 4'd1;
                    end else begin
                        wc          <= 4'd0;
                        currState   <= FETCH;
                        instr_count <= instr_count + 32'd1;
                    end
                end
                ALU_WB, MEM_WB, BRANCH, JUMP: begin
                    currState   <= FETCH;
                    instr_count <= instr_count + 32'd1;
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        currState   <= FETCH;
                        instr_count <= instr_count + 32'd1;
                    end
                end
                OUT_WAIT: begin
                    if (out_ready) begin
                        currState   <= FETCH;
                        instr_count <= instr_count + 32'd1;
                    end
                end
                HALT:    currState <= HALT;
                default: currState <= FETCH;
            endcase
        end
    end

    // Datapath controls are decoded from the current state, the wait counter
    // and the live inputs, so handshake and branch responses land in the same
    // cycle. Everything defaults to 0, and reset holds every control low.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 3'd0;
        in_ack     = 1'b0;
        out_valid  = 1'b0;
        if (!reset) begin
            case (currState)
                FETCH: begin
                    mem_read = 1'b1;
                    if (waitDone) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'd1;
                    end
                end
                DECODE: alu_src_b = 2'd3;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'd2;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = 3'd3;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEM_READ: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                MEM_WRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'd1;
                    pc_src    = 2'd1;
                    pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = (opcode == OP_RTYPE) ? 2'd3 : 2'd2;
                    // PC already holds PC+4 here, so JAL links it straight into r31
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'd3;
                        in_ack     = 1'b1;
                    end
                end
                OUT_WAIT: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    out_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for unidade_controle_multiciclo: directed instruction sequences
// with hand-computed state traces and control values. The main instance runs
// with MEM_WAIT=2; a second instance with MEM_WAIT=1 runs the R-type trace.
module tb_unidade_controle_multiciclo;

    localparam int W = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;

    logic        pcWrite, irWrite, memRead, memWrite, iOrD, regWrite, aluSrcA, inAck, outValid;
    logic [1:0]  pcSrc, regDst, memToReg, aluSrcB;
    logic [2:0]  aluOp;
    logic        halted, illegal;
    logic [3:0]  state;
    logic [31:0] instrCount;

    logic        w1PcWrite, w1IrWrite, w1MemRead, w1MemWrite, w1IOrD, w1RegWrite, w1AluSrcA, w1InAck, w1OutValid;
    logic [1:0]  w1PcSrc, w1RegDst, w1MemToReg, w1AluSrcB;
    logic [2:0]  w1AluOp;
    logic        w1Halted, w1Illegal;
    logic [3:0]  w1State;
    logic [31:0] w1InstrCount;

    logic [19:0] strobes;
    logic [19:0] w1Strobes;

    int checks = 0;
    int failures = 0;

    assign strobes   = {pcWrite, pcSrc, irWrite, memRead, memWrite, iOrD, regWrite, regDst,
                        memToReg, aluSrcA, aluSrcB, aluOp, inAck, outValid};
    assign w1Strobes = {w1PcWrite, w1PcSrc, w1IrWrite, w1MemRead, w1MemWrite, w1IOrD, w1RegWrite, w1RegDst,
                        w1MemToReg, w1AluSrcA, w1AluSrcB, w1AluOp, w1InAck, w1OutValid};

    always #5 clock = ~clock;

    unidade_controle_multiciclo #(.MEM_WAIT(W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .in_valid(inValid), .out_ready(outReady),
        .pc_write(pcWrite), .pc_src(pcSrc), .ir_write(irWrite), .mem_read(memRead),
        .mem_write(memWrite), .i_or_d(iOrD), .reg_write(regWrite), .reg_dst(regDst),
        .mem_to_reg(memToReg), .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_op(aluOp),
        .in_ack(inAck), .out_valid(outValid), .halted(halted), .illegal(illegal),
        .state(state), .instr_count(instrCount)
    );

    unidade_controle_multiciclo #(.MEM_WAIT(1)) dutW1 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .in_valid(inValid), .out_ready(outReady),
        .pc_write(w1PcWrite), .pc_src(w1PcSrc), .ir_write(w1IrWrite), .mem_read(w1MemRead),
        .mem_write(w1MemWrite), .i_or_d(w1IOrD), .reg_write(w1RegWrite), .reg_dst(w1RegDst),
        .mem_to_reg(w1MemToReg), .alu_src_a(w1AluSrcA), .alu_src_b(w1AluSrcB), .alu_op(w1AluOp),
        .in_ack(w1InAck), .out_valid(w1OutValid), .halted(w1Halted), .illegal(w1Illegal),
        .state(w1State), .instr_count(w1InstrCount)
    );

    // Advance one cycle and sample just after the falling edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Hold reset across one rising edge; returns at a falling edge with reset still high.
    task automatic doReset();
        @(negedge clock);
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        zero     = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        doReset();
        inValid = 1'b1; outReady = 1'b1; zero = 1'b1; opcode = 6'h3E;
        #1;
        checks++; if (state !== 4'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        checks++; if (instrCount !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", instrCount); end
        checks++; if ({halted, illegal} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {halted, illegal}); end
        checks++; if (strobes !== 20'd0) begin failures++; $display("[TB] FAIL reset_strobes got=%h exp=0", strobes); end
        checks++; if ({w1Strobes, w1Halted, w1Illegal} !== 22'd0) begin failures++; $display("[TB] FAIL reset_w1_outputs got=%h exp=0", {w1Strobes, w1Halted, w1Illegal}); end
        inValid = 1'b0; outReady = 1'b0; zero = 1'b0;
    endtask

    task automatic test_rtype_w1();
        logic [3:0] expSeq [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd12, 4'd0};
        doReset();
        reset = 1'b0; opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) #1; else tick();
            checks++; if (w1State !== expSeq[i]) begin failures++; $display("[TB] FAIL add_w1_state cycle=%0d got=%0d exp=%0d", i, w1State, expSeq[i]); end
            checks++; if (w1RegWrite !== (expSeq[i] == 4'd12)) begin failures++; $display("[TB] FAIL add_w1_reg_write cycle=%0d got=%b", i, w1RegWrite); end
            if (expSeq[i] == 4'd12) begin
                checks++; if (w1RegDst !== 2'd1) begin failures++; $display("[TB] FAIL add_w1_reg_dst got=%0d exp=1", w1RegDst); end
            end
        end
        checks++; if (w1InstrCount !== 32'd1) begin failures++; $display("[TB] FAIL add_w1_count got=%0d exp=1", w1InstrCount); end
    endtask

    task automatic test_itype();
        doReset();
        reset = 1'b0; opcode = 6'h08;
        #1;
        repeat (W + 2) tick();
        checks++; if ({state, aluSrcA, aluSrcB, aluOp} !== {4'd3, 1'b1, 2'd2, 3'd3}) begin failures++; $display("[TB] FAIL addi_exec got=%h exp=%h", {state, aluSrcA, aluSrcB, aluOp}, {4'd3, 1'b1, 2'd2, 3'd3}); end
        tick();
        checks++; if ({state, regWrite, regDst, memToReg} !== {4'd12, 1'b1, 2'd0, 2'd0}) begin failures++; $display("[TB] FAIL addi_wb got=%h exp=%h", {state, regWrite, regDst, memToReg}, {4'd12, 1'b1, 2'd0, 2'd0}); end
        tick();
        checks++; if (instrCount !== 32'd1) begin failures++; $display("[TB] FAIL addi_count got=%0d exp=1", instrCount); end
    endtask

    task automatic test_mem();
        logic [3:0] expLw [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd0};
        doReset();
        reset = 1'b0; opcode = 6'h23;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) #1; else tick();
            checks++; if (state !== expLw[i]) begin failures++; $display("[TB] FAIL lw_state cycle=%0d got=%0d exp=%0d", i, state, expLw[i]); end
            if (i < 9) begin
                checks++; if (memRead !== (expLw[i] == 4'd0 || expLw[i] == 4'd5)) begin failures++; $display("[TB] FAIL lw_mem_read cycle=%0d got=%b", i, memRead); end
                checks++; if (iOrD !== (expLw[i] == 4'd5)) begin failures++; $display("[TB] FAIL lw_i_or_d cycle=%0d got=%b", i, iOrD); end
            end
            if (i == 8) begin
                checks++; if ({regWrite, regDst, memToReg} !== {1'b1, 2'd0, 2'd1}) begin failures++; $display("[TB] FAIL lw_wb got=%b exp=10001", {regWrite, regDst, memToReg}); end
            end
        end
        checks++; if (instrCount !== 32'd1) begin failures++; $display("[TB] FAIL lw_count got=%0d exp=1", instrCount); end
        opcode = 6'h2B;
        repeat (W + 1) tick();
        checks++; if (state !== 4'd1) begin failures++; $display("[TB] FAIL sw_decode got=%0d exp=1", state); end
        tick();
        checks++; if (state !== 4'd4) begin failures++; $display("[TB] FAIL sw_addr got=%0d exp=4", state); end
        for (int i = 0; i <= W; i++) begin
            tick();
            checks++; if ({state, memWrite, iOrD, memRead} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL sw_write cycle=%0d got=%h exp=%h", i, {state, memWrite, iOrD, memRead}, {4'd7, 3'b110}); end
        end
        tick();
        checks++; if ({state, instrCount} !== {4'd0, 32'd2}) begin failures++; $display("[TB] FAIL sw_done got=%0d/%0d exp=0/2", state, instrCount); end
    endtask

    task automatic test_branch();
        logic [5:0] ops [3]   = '{6'h04, 6'h05, 6'h04};
        logic       zs [3]    = '{1'b0, 1'b0, 1'b1};
        logic       expPcw [3] = '{1'b0, 1'b1, 1'b1};
        doReset();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k]; zero = zs[k];
            repeat (W + 2) tick();
            checks++; if ({state, pcWrite, pcSrc, aluOp} !== {4'd8, expPcw[k], 2'd1, 3'd1}) begin failures++; $display("[TB] FAIL branch_%0d got=%h exp=%h", k, {state, pcWrite, pcSrc, aluOp}, {4'd8, expPcw[k], 2'd1, 3'd1}); end
            tick();
            checks++; if ({state, instrCount} !== {4'd0, 32'(k + 1)}) begin failures++; $display("[TB] FAIL branch_retire_%0d got=%0d/%0d exp=0/%0d", k, state, instrCount, k + 1); end
        end
    endtask

    task automatic test_in();
        doReset();
        reset = 1'b0; opcode = 6'h3E; inValid = 1'b1;
        #1;
        checks++; if (inAck !== 1'b0) begin failures++; $display("[TB] FAIL in_ack_in_fetch got=%b exp=0", inAck); end
        repeat (W + 1) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); inValid = 1'b0; #1;
            checks++; if ({state, inAck, regWrite} !== {4'd10, 2'b00}) begin failures++; $display("[TB] FAIL in_wait cycle=%0d got=%h exp=%h", i, {state, inAck, regWrite}, {4'd10, 2'b00}); end
        end
        @(negedge clock); inValid = 1'b1; #1;
        checks++; if ({state, inAck, regWrite, regDst, memToReg} !== {4'd10, 1'b1, 1'b1, 2'd0, 2'd3}) begin failures++; $display("[TB] FAIL in_accept got=%h exp=%h", {state, inAck, regWrite, regDst, memToReg}, {4'd10, 1'b1, 1'b1, 2'd0, 2'd3}); end
        @(negedge clock); inValid = 1'b0; #1;
        checks++; if ({state, inAck, instrCount} !== {4'd0, 1'b0, 32'd1}) begin failures++; $display("[TB] FAIL in_done got=%h exp=%h", {state, inAck, instrCount}, {4'd0, 1'b0, 32'd1}); end
        repeat (W + 2) tick();
        checks++; if (state !== 4'd10) begin failures++; $display("[TB] FAIL in_reenter got=%0d exp=10", state); end
        @(negedge clock); reset = 1'b1; inValid = 1'b1; #1;
        checks++; if (strobes !== 20'd0) begin failures++; $display("[TB] FAIL in_abort_strobes got=%h exp=0", strobes); end
        tick();
        checks++; if ({state, instrCount} !== {4'd0, 32'd0}) begin failures++; $display("[TB] FAIL in_abort_state got=%0d/%0d exp=0/0", state, instrCount); end
        inValid = 1'b0;
    endtask

    task automatic test_out();
        doReset();
        reset = 1'b0; opcode = 6'h3F; outReady = 1'b1;
        #1;
        repeat (W + 2) tick();
        checks++; if ({state, outValid, aluSrcA, aluSrcB, aluOp} !== {4'd11, 1'b1, 1'b1, 2'd2, 3'd0}) begin failures++; $display("[TB] FAIL out_immediate got=%h", {state, outValid, aluSrcA, aluSrcB, aluOp}); end
        tick();
        checks++; if ({state, instrCount} !== {4'd0, 32'd1}) begin failures++; $display("[TB] FAIL out_immediate_done got=%0d/%0d exp=0/1", state, instrCount); end
        outReady = 1'b0;
        repeat (W + 3) tick();
        checks++; if ({state, outValid} !== {4'd11, 1'b1}) begin failures++; $display("[TB] FAIL out_stall got=%h exp=%h", {state, outValid}, {4'd11, 1'b1}); end
        @(negedge clock); outReady = 1'b1; #1;
        checks++; if (state !== 4'd11) begin failures++; $display("[TB] FAIL out_last got=%0d exp=11", state); end
        @(negedge clock); outReady = 1'b0; #1;
        checks++; if ({state, instrCount} !== {4'd0, 32'd2}) begin failures++; $display("[TB] FAIL out_done got=%0d/%0d exp=0/2", state, instrCount); end
    endtask

    task automatic test_jump();
        doReset();
        reset = 1'b0; opcode = 6'h03;
        #1;
        repeat (W + 2) tick();
        checks++; if ({state, pcWrite, pcSrc, regWrite, regDst, memToReg} !== {4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2}) begin failures++; $display("[TB] FAIL jal got=%h", {state, pcWrite, pcSrc, regWrite, regDst, memToReg}); end
        tick();
        opcode = 6'h00; funct = 6'h08;
        repeat (W + 2) tick();
        checks++; if ({state, pcWrite, pcSrc, regWrite} !== {4'd9, 1'b1, 2'd3, 1'b0}) begin failures++; $display("[TB] FAIL jr got=%h", {state, pcWrite, pcSrc, regWrite}); end
        tick();
        checks++; if (instrCount !== 32'd2) begin failures++; $display("[TB] FAIL jump_count got=%0d exp=2", instrCount); end
    endtask

    task automatic test_halt();
        doReset();
        reset = 1'b0; opcode = 6'h3D;
        #1;
        repeat (W + 1) tick();
        checks++; if ({state, halted} !== {4'd1, 1'b0}) begin failures++; $display("[TB] FAIL halt_decode got=%h", {state, halted}); end
        tick();
        checks++; if ({state, halted, illegal, instrCount} !== {4'd13, 1'b1, 1'b0, 32'd1}) begin failures++; $display("[TB] FAIL halt_legal got=%h", {state, halted, illegal, instrCount}); end
        doReset();
        reset = 1'b0; opcode = 6'h3C;
        #1;
        repeat (W + 2) tick();
        checks++; if ({state, halted, illegal} !== {4'd13, 1'b1, 1'b1}) begin failures++; $display("[TB] FAIL halt_illegal got=%h", {state, halted, illegal}); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            inValid = 1'($urandom); outReady = 1'($urandom);
            #1;
            checks++; if ({state, strobes, halted, illegal, instrCount} !== {4'd13, 20'd0, 2'b11, 32'd1}) begin failures++; $display("[TB] FAIL halt_sticky cycle=%0d got=%h", i, {state, strobes, halted, illegal, instrCount}); end
        end
        doReset();
        #1;
        checks++; if ({state, halted, illegal, instrCount} !== {4'd0, 2'b00, 32'd0}) begin failures++; $display("[TB] FAIL halt_reset got=%h", {state, halted, illegal, instrCount}); end
    endtask

    task automatic test_wrap();
        doReset();
        reset = 1'b0; opcode = 6'h02;
        #1;
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        repeat (W + 2) tick();
        checks++; if ({state, instrCount} !== {4'd9, 32'hFFFF_FFFF}) begin failures++; $display("[TB] FAIL wrap_preset got=%0d/%h exp=9/ffffffff", state, instrCount); end
        tick();
        checks++; if ({state, instrCount} !== {4'd0, 32'd0}) begin failures++; $display("[TB] FAIL wrap got=%0d/%h exp=0/00000000", state, instrCount); end
    endtask

    // Directed scenarios in sequence, then the summary line.
    initial begin
        test_reset();
        test_rtype_w1();
        test_itype();
        test_mem();
        test_branch();
        test_in();
        test_out();
        test_jump();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

endmodule
